seg_scan_driver: RTL and testbench

Time-multiplexed scan driver for a 3-digit common-bus 7-segment display. It sits directly downstream of the 3-digit counter/decoder block and consumes its three segment patterns (seg0 = ones, seg1 = tens, seg2 = hundreds). It drives one shared 8-bit segment bus plus three one-hot digit enables. Features:
- Tear-free per-frame latching of the input patterns.
- Anti-ghosting blank gap at every digit switch.
- 8-level brightness control.
- Optional leading-zero suppression.

---
 rtl/seg_scan_driver.sv | 117 +++++++++++
 tb/tb_seg_scan_driver.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed scan driver for a 3-digit common-bus 7-segment display.
// Latches the three digit patterns once per frame, then drives each digit in turn with a blank gap, PWM brightness and leading-zero blanking.
module seg_scan_driver #(
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 8,
  parameter int ON_UNIT   = 64,
  parameter bit LZ_BLANK  = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] seg0,
  input  logic [7:0] seg1,
  input  logic [7:0] seg2,
  input  logic [2:0] bright,
  output logic [7:0] seg_out,
  output logic [2:0] dig_en,
  output logic       frame_done
);

  localparam logic [7:0] ZERO_PAT = 8'hFC;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       idx, idx_n;
  logic [7:0]       p0, p1, p2, p0_n, p1_n, p2_n;
  logic [2:0]       b, b_n;
  logic [7:0]       seg_n;
  logic [2:0]       dig_n;
  logic             fd_n;
  logic [7:0]       cur_pat;
  logic [31:0]      on_end;
  logic             on_phase;
  logic             suppress;

  always_comb begin
    cur_pat = p0;
    case (idx)
      2'd1:    cur_pat = p1;
      2'd2:    cur_pat = p2;
      default: cur_pat = p0;
    endcase
  end

  // On window is measured from the end of the blank gap using the frame's brightness snapshot.
  always_comb begin
    on_end   = 32'(BLANK_CYC) + 32'(ON_UNIT) * (32'(b) + 32'd1);
    on_phase = (32'(cnt) >= 32'(BLANK_CYC)) && (32'(cnt) < on_end);
    suppress = LZ_BLANK &&
               (((idx == 2'd2) && (p2 == ZERO_PAT)) ||
                ((idx == 2'd1) && (p2 == ZERO_PAT) && (p1 == ZERO_PAT)));
  end

  always_comb begin
    cnt_n = cnt;
    idx_n = idx;
    p0_n  = p0;
    p1_n  = p1;
    p2_n  = p2;
    b_n   = b;
    seg_n = 8'h00;
    dig_n = 3'b000;
    fd_n  = 1'b0;
    if (!en) begin
      cnt_n = '0;
      idx_n = 2'd0;
    end else begin
      if ((cnt == '0) && (idx == 2'd0)) begin
        p0_n = seg0;
        p1_n = seg1;
        p2_n = seg2;
        b_n  = bright;
      end
      if (cnt == CNT_LAST) begin
        cnt_n = '0;
        if (idx == 2'd2) begin
          idx_n = 2'd0;
          fd_n  = 1'b1;
        end else begin
          idx_n = idx + 2'd1;
        end
      end else begin
        cnt_n = cnt + 1'b1;
      end
      if (on_phase && !suppress) begin
        dig_n = 3'b001 << idx;
        seg_n = cur_pat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= 2'd0;
      p0         <= ZERO_PAT;
      p1         <= ZERO_PAT;
      p2         <= ZERO_PAT;
      b          <= 3'd7;
      seg_out    <= 8'h00;
      dig_en     <= 3'b000;
      frame_done <= 1'b0;
    end else begin
      cnt        <= cnt_n;
      idx        <= idx_n;
      p0         <= p0_n;
      p1         <= p1_n;
      p2         <= p2_n;
      b          <= b_n;
      seg_out    <= seg_n;
      dig_en     <= dig_n;
      frame_done <= fd_n;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed scenarios plus random traffic, every cycle compared against a frame-position model.
module tb_seg_scan_driver;

  localparam int SD = 20;
  localparam int BC = 2;
  localparam int OU = 2;
  localparam int FRAME = 3 * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic [7:0] seg0 = 8'hFC;
  logic [7:0] seg1 = 8'hFC;
  logic [7:0] seg2 = 8'hFC;
  logic [2:0] bright = 3'd7;
  logic [7:0] seg_out;
  logic [2:0] dig_en;
  logic       frame_done;

  int total = 0;
  int bad = 0;

  // model state: enabled cycles since the frame train started, and the frame snapshot
  int         pos = 0;
  logic [7:0] ms [3];
  int         mb = 7;
  int         drive_cnt [3];

  always #5 clk = ~clk;

  seg_scan_driver #(
    .SCAN_DIV(SD), .BLANK_CYC(BC), .ON_UNIT(OU), .LZ_BLANK(1'b1), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .seg0(seg0), .seg1(seg1), .seg2(seg2),
    .bright(bright), .seg_out(seg_out), .dig_en(dig_en), .frame_done(frame_done)
  );

  task automatic cycle();
    logic [7:0] e_seg;
    logic [2:0] e_dig;
    logic       e_fd;
    int slot, off;
    bit sup;
    e_seg = 8'h00;
    e_dig = 3'b000;
    e_fd  = 1'b0;
    if (rst) begin
      pos = 0;
      ms[0] = 8'hFC; ms[1] = 8'hFC; ms[2] = 8'hFC;
      mb = 7;
    end else if (!en) begin
      pos = 0;
    end else begin
      if (pos % FRAME == 0) begin
        ms[0] = seg0; ms[1] = seg1; ms[2] = seg2;
        mb = int'(bright);
      end
      slot = (pos / SD) % 3;
      off  = pos % SD;
      sup  = (slot == 2 && ms[2] == 8'hFC) ||
             (slot == 1 && ms[2] == 8'hFC && ms[1] == 8'hFC);
      if (off >= BC && off < BC + OU * (mb + 1) && !sup) begin
        e_dig = 3'b001 << slot;
        e_seg = ms[slot];
      end
      e_fd = (pos % FRAME == FRAME - 1);
      pos++;
    end
    @(posedge clk);
    #1;
    total++;
    assert (seg_out === e_seg) else begin
      bad++;
      $error("FAIL seg_out pos=%0d got %h exp %h", pos, seg_out, e_seg);
    end
    total++;
    assert (dig_en === e_dig) else begin
      bad++;
      $error("FAIL dig_en pos=%0d got %b exp %b", pos, dig_en, e_dig);
    end
    total++;
    assert (frame_done === e_fd) else begin
      bad++;
      $error("FAIL frame_done pos=%0d got %b exp %b", pos, frame_done, e_fd);
    end
    total++;
    assert ($onehot0(dig_en)) else begin
      bad++;
      $error("FAIL onehot got %b exp at most one bit", dig_en);
    end
    for (int d = 0; d < 3; d++) if (dig_en[d]) drive_cnt[d]++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_to(input int k);
    int guard;
    guard = 0;
    while ((pos % FRAME) != k && guard < 200) begin
      cycle();
      guard++;
    end
    total++;
    assert (guard < 200) else begin
      bad++;
      $error("FAIL run_to got guard=%0d exp <200", guard);
    end
  endtask

  task automatic clear_counts();
    for (int d = 0; d < 3; d++) drive_cnt[d] = 0;
  endtask

  task automatic check_counts(input string tag, input int c0, input int c1, input int c2);
    total++;
    assert (drive_cnt[0] == c0 && drive_cnt[1] == c1 && drive_cnt[2] == c2) else begin
      bad++;
      $error("FAIL %s got %0d/%0d/%0d exp %0d/%0d/%0d", tag,
             drive_cnt[0], drive_cnt[1], drive_cnt[2], c0, c1, c2);
    end
  endtask

  initial begin
    logic [7:0] pats [11];
    pats = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6, 8'h00};

    // reset held with en=1
    run(3);
    rst = 1'b0;

    // "000": only digit 0 driven
    clear_counts();
    run(FRAME);
    check_counts("lz_000", 16, 0, 0);

    // "215" full brightness
    seg0 = 8'hB6; seg1 = 8'h60; seg2 = 8'hDA; bright = 3'd7;
    clear_counts();
    run(2 * FRAME);
    check_counts("bright7", 32, 32, 32);

    // dim, brightness change mid-frame
    bright = 3'd0;
    clear_counts();
    run(FRAME);
    check_counts("bright0", 2, 2, 2);
    run(30);
    bright = 3'd5;
    run_to(0);
    run(FRAME);

    // tear-free latching of seg1
    run_to(25);
    seg1 = 8'hE0;
    run_to(0);
    run(FRAME);

    // "007" and "070"
    seg0 = 8'hE0; seg1 = 8'hFC; seg2 = 8'hFC; bright = 3'd7;
    run_to(0);
    clear_counts();
    run(FRAME);
    check_counts("lz_007", 16, 0, 0);
    seg0 = 8'hFC; seg1 = 8'hE0; seg2 = 8'hFC;
    clear_counts();
    run(FRAME);
    check_counts("lz_070", 16, 16, 0);

    // abort at frame cycle 30, then re-enable with new inputs
    seg0 = 8'h60; seg1 = 8'hDA; seg2 = 8'hF2;
    run_to(30);
    en = 1'b0;
    run(4);
    seg0 = 8'h66;
    en = 1'b1;
    run(2 * FRAME);

    // random traffic with occasional enable drops and resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        seg0 = pats[$urandom_range(0, 10)];
        seg1 = pats[$urandom_range(0, 10)];
        seg2 = pats[$urandom_range(0, 10)];
        bright = 3'($urandom_range(0, 7));
      end
      en  = ($urandom_range(0, 59) != 0);
      rst = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 1'b0;
    en  = 1'b1;
    run(FRAME);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
